// File: rtl/reflet_fifo_port.sv
// Memory-mapped byte-stream responder for the reflet_cpu data bus.
// Holds a CPU-filled TX FIFO drained by a valid/ready stream and a stream-filled RX FIFO popped by the CPU.
module reflet_fifo_port #(
    parameter int                  wordsize  = 8,
    parameter logic [wordsize-1:0] base_addr = 8'hF0,
    parameter int                  depth     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [wordsize-1:0] addr,
    input  logic [wordsize-1:0] data_in,
    input  logic                write_en,
    output logic [wordsize-1:0] data_out,
    output logic [wordsize-1:0] tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [wordsize-1:0] rx_data,
    input  logic                rx_valid,
    output logic                rx_ready
);

    localparam int          AW       = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(depth);

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_POP    = 2'd2,
        REG_CTRL   = 2'd3
    } reg_sel_t;

    logic [wordsize-1:0] r_tx_mem [depth];
    logic [wordsize-1:0] r_rx_mem [depth];

    logic [AW-1:0]       r_tx_wptr, r_tx_rptr;
    logic [AW-1:0]       r_rx_wptr, r_rx_rptr;
    logic [AW:0]         r_tx_cnt, r_rx_cnt;
    logic                r_tx_ovf, r_rx_unf;
    logic [wordsize-1:0] r_rdata;

    logic                w_hit;
    reg_sel_t            w_reg;
    logic                w_cpu_wr;
    logic                w_wr_data, w_wr_status, w_wr_pop, w_wr_ctrl;
    logic                w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic                w_tx_push, w_tx_pop, w_tx_flush;
    logic                w_rx_push, w_rx_pop, w_rx_flush;
    logic [wordsize-1:0] w_status;
    logic [wordsize-1:0] w_rdata_next;

    // Address decode and per-register write strobes
    assign w_hit       = (addr[wordsize-1:2] == base_addr[wordsize-1:2]);
    assign w_reg       = reg_sel_t'(addr[1:0]);
    assign w_cpu_wr    = write_en & w_hit;
    assign w_wr_data   = w_cpu_wr & (w_reg == REG_DATA);
    assign w_wr_status = w_cpu_wr & (w_reg == REG_STATUS);
    assign w_wr_pop    = w_cpu_wr & (w_reg == REG_POP);
    assign w_wr_ctrl   = w_cpu_wr & (w_reg == REG_CTRL);

    // All full/empty decisions come from the counts held at the start of the cycle
    assign w_tx_full  = (r_tx_cnt == CNT_FULL);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == CNT_FULL);
    assign w_rx_empty = (r_rx_cnt == '0);

    assign w_tx_flush = w_wr_ctrl & data_in[0];
    assign w_rx_flush = w_wr_ctrl & data_in[1];
    assign w_tx_push  = w_wr_data & ~w_tx_full & ~w_tx_flush;
    assign w_tx_pop   = ~w_tx_empty & tx_ready & ~w_tx_flush;
    assign w_rx_push  = rx_valid & ~w_rx_full & ~w_rx_flush;
    assign w_rx_pop   = w_wr_pop & ~w_rx_empty & ~w_rx_flush;

    assign tx_valid = ~w_tx_empty;
    assign tx_data  = r_tx_mem[r_tx_rptr];
    assign rx_ready = ~w_rx_full;
    assign data_out = r_rdata;

    always_comb begin
        w_status      = '0;
        w_status[5:0] = {r_rx_unf, r_tx_ovf, w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};
    end

    always_comb begin
        w_rdata_next = '0;
        if (w_hit) begin
            unique case (w_reg)
                REG_DATA:   w_rdata_next = w_rx_empty ? '0 : r_rx_mem[r_rx_rptr];
                REG_STATUS: w_rdata_next = w_status;
                default:    w_rdata_next = '0;
            endcase
        end
    end

    // Storage arrays carry no reset; pointers and counts define what is valid
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= data_in;
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= rx_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
            r_tx_cnt  <= '0;
        end else if (w_tx_flush) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
            r_tx_cnt  <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
            unique case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
                2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
            r_rx_cnt  <= '0;
        end else if (w_rx_flush) begin
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
            r_rx_cnt  <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            unique case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
                2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // Sticky flags: one register is targeted per write cycle, so set and clear never collide
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_ovf <= 1'b0;
            r_rx_unf <= 1'b0;
        end else begin
            if (w_wr_data && w_tx_full)
                r_tx_ovf <= 1'b1;
            else if (w_wr_status && data_in[4])
                r_tx_ovf <= 1'b0;

            if (w_wr_pop && w_rx_empty)
                r_rx_unf <= 1'b1;
            else if (w_wr_status && data_in[5])
                r_rx_unf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rdata <= '0;
        else        r_rdata <= w_rdata_next;
    end

endmodule
